ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
AHB-lite slave with a word-organised SRAM behind it. It is the DUT-side consumer of the bus signals that the testbench master drives: it samples address and control, then returns hrdata/hreadyout/hresp. Features are a programmable wait-state count, byte/halfword/word lanes, and a two-cycle ERROR response for illegal transfers. All bursts are handled as a sequence of independent single transfers; hburst and hprot are accepted but ignored.

Parameters:
ADDR_WIDTH, 32, width of haddr
DATA_WIDTH, 32, width of hwdata/hrdata (only 32 supported)
MEM_DEPTH, 256, number of 32-bit words; valid byte addresses are 0 .. 4*MEM_DEPTH-1
WAIT_STATES, 0, number of hreadyout-low cycles inserted in every OKAY data phase (0..15)

Ports:
hclk  input  1  bus clock, all logic on posedge
hresetn  input  1  asynchronous active-low reset
hsel  input  1  slave select
haddr  input  ADDR_WIDTH  byte address
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1 = write
hsize  input  3  000 byte, 001 half, 010 word
hburst  input  3  burst type, ignored
hprot  input  4  protection, ignored
hready  input  1  bus-level ready; address phase is sampled only when high
hwdata  input  DATA_WIDTH  write data, valid in data phase
hrdata  output  DATA_WIDTH  read data
hreadyout  output  1  slave ready
hresp  output  2  00 OKAY, 01 ERROR

Behaviour:
- Reset (hresetn low, asynchronous): state=IDLE, hreadyout=1, hresp=00, hrdata=0, wait counter=0, latched control cleared. Memory contents are not reset.
- Transfer accepted on a posedge when hsel & hready & htrans[1]=1. On acceptance, the block latches haddr, hwrite, hsize, and a legal flag.
- IDLE/BUSY, or hsel=0 with hready=1: no access, and the next cycle drives a zero-wait OKAY.
- Illegal transfer if any of these hold:
  - hsize > 010
  - misaligned (half with haddr[0]=1; word with haddr[1:0]!=0)
  - haddr >= 4*MEM_DEPTH
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: legal accept -> WAIT if WAIT_STATES>0, else DATA. Illegal accept -> ERR1.
  - WAIT: hreadyout=0, hresp=00. Counter decrements each cycle; at 1 -> DATA.
  - DATA: hreadyout=1, hresp=00. Transfer completes this cycle. A new accept in the same cycle re-enters WAIT/DATA/ERR1; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=01 -> ERR2.
  - ERR2: hreadyout=1, hresp=01. No memory access. A new accept is handled as from DATA.
- Latency: with WAIT_STATES=N, every OKAY data phase lasts N+1 cycles. An ERROR data phase always lasts 2 cycles, independent of N.
- Write: at the posedge ending DATA, hwdata is written with byte enables derived from the latched hsize and addr[1:0], little-endian. Byte lane k = hwdata[8k+7:8k]. Other bytes are unchanged.
- Read: while in DATA, hrdata = mem[latched_addr>>2] as the full word; the master extracts the lane. hrdata=0 in all other states.
- Read immediately after a write to the same word returns the new data (write committed before the read data phase).
- Pipelining: during WAIT/ERR1, hready is low, so no new address is sampled. The master's held address is accepted at the completing edge.
- Reset asserted mid-transfer: the transfer is aborted and no write occurs. After reset release, the first address phase is handled normally.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> hrdata=0xDEADBEEF in the read data phase, hreadyout high every cycle, hresp=00.
- Byte lanes: write word 0x00000000 @0x20, then byte 0xAA @0x22 (hwdata=0x00AA0000), then half 0x1234 @0x20 -> word read @0x20 returns 0x00AA1234.
- WAIT_STATES=3: single read -> hreadyout low for exactly 3 cycles, then high with data. The next NONSEQ, held during the waits, is accepted on the completing edge.
- Errors: word write @0x3 (misaligned), then hsize=011, then address 0x400 with MEM_DEPTH=256. Each gives hreadyout 0 then 1 with hresp=01 on both cycles, and a subsequent read of word 0 is unchanged.
- IDLE/BUSY and hsel=0 interleaved in a SEQ stream -> zero-wait OKAY, no memory change, hrdata=0 in those cycles.
- Reset mid-flight: WAIT_STATES=2 write of 0x55555555 @0x8, hresetn pulsed low during WAIT -> hreadyout=1, hresp=00 immediately, and a read @0x8 returns the prior value.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite slave in front of a word-organised SRAM: programmable wait states,
// byte/halfword/word lanes, and a two-cycle ERROR response for illegal transfers.
`timescale 1ns/1ps
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [2:0]            o_dbg_state
);

  localparam int                    IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LP_LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0]            LP_WAITS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Handshake: an address phase is taken on a rising edge only when
  // hsel & hready & htrans[1]; the data phase ends on the first edge with hreadyout=1.
  state_t                r_state, w_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [IDX_W+1:0]      r_addr;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_legal;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_open, w_accept, w_misalign, w_legal, w_we;
  logic [3:0]            w_be;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_unused;

  assign w_unused   = ^{hburst, hprot, htrans[0]};
  assign w_open     = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept   = w_open && hsel && hready && htrans[1];
  assign w_misalign = ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  assign w_legal    = (hsize <= 3'b010) && !w_misalign && (haddr < LP_LIMIT);
  assign w_idx      = r_addr[IDX_W+1:2];
  assign w_we       = hresetn && (r_state == ST_DATA) && r_write && r_legal;
  assign o_dbg_state = r_state;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_legal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= haddr[IDX_W+1:0];
        r_write <= hwrite;
        r_size  <= hsize[1:0];
        r_legal <= w_legal;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = ST_DATA;
      end
      ST_ERR1: w_next = ST_ERR2;
      default: begin
        w_next = ST_IDLE;
        if (w_accept) begin
          if (!w_legal) begin
            w_next = ST_ERR1;
          end else if (LP_WAITS != 4'd0) begin
            w_next     = ST_WAIT;
            w_cnt_next = LP_WAITS;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
    endcase
  end

  always_comb begin
    hreadyout = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
    hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? 2'b01 : 2'b00;
    hrdata    = '0;
    if (r_state == ST_DATA) hrdata = r_mem[w_idx];
  end

  // Little-endian lanes; only legal transfers ever reach DATA.
  always_comb begin
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= hwdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 3 and 2 wait states) share one
// bus; a byte-level memory model predicts each data phase and a monitor checks it.
`timescale 1ns/1ps
module tb_ahb_lite_sram_slave;

  localparam int ND = 3;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel_bus = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = T_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [2:0]  hburst = '0;
  logic [3:0]  hprot = '0;
  logic [31:0] hwdata = '0;

  logic [ND-1:0] hsel_v;
  logic [31:0]   hrdata_v    [ND];
  logic          hreadyout_v [ND];
  logic [1:0]    hresp_v     [ND];
  logic [2:0]    dbg_v       [ND];
  int            act = 0;
  logic          hready;
  logic [31:0]   hrdata_m;
  logic [1:0]    hresp_m;

  always_comb begin
    hsel_v      = '0;
    hsel_v[act] = hsel_bus;
    hready      = hreadyout_v[act];
    hrdata_m    = hrdata_v[act];
    hresp_m     = hresp_v[act];
  end

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
    .hwdata(hwdata), .hrdata(hrdata_v[0]), .hreadyout(hreadyout_v[0]), .hresp(hresp_v[0]),
    .o_dbg_state(dbg_v[0]));
  ahb_lite_sram_slave #(.WAIT_STATES(3)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
    .hwdata(hwdata), .hrdata(hrdata_v[1]), .hreadyout(hreadyout_v[1]), .hresp(hresp_v[1]),
    .o_dbg_state(dbg_v[1]));
  ahb_lite_sram_slave #(.WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
    .hwdata(hwdata), .hrdata(hrdata_v[2]), .hreadyout(hreadyout_v[2]), .hresp(hresp_v[2]),
    .o_dbg_state(dbg_v[2]));

  // ---------------- clock ----------------
  always #5 hclk = ~hclk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [3:0]  waits;
    logic        chk_rd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl   [ND][256];
  bit          known [ND][256];

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t (dut %0d)", name, got, want, $time, act);
    end
  endtask

  // Predicts one accepted transfer and applies any write to the model.
  function automatic exp_t model_xfer(input int d, input logic [31:0] addr, input logic wr,
                                      input logic [2:0] sz, input logic [31:0] wd);
    exp_t        e;
    int unsigned nb, off, idx;
    bit          legal;
    legal = 1'b1;
    if (sz > 3'd2) legal = 1'b0;
    else if ((addr % (32'd1 << sz)) != 0) legal = 1'b0;
    if (addr >= 32'd1024) legal = 1'b0;
    if (!legal) begin
      e.resp = 2'b01; e.rdata = '0; e.waits = 4'd1; e.chk_rd = 1'b1;
    end else begin
      idx      = addr / 4;
      e.resp   = 2'b00;
      e.rdata  = mdl[d][idx];
      e.waits  = 4'(ws_of(d));
      e.chk_rd = known[d][idx];
      if (wr) begin
        nb  = 32'd1 << sz;
        off = addr % 4;
        for (int unsigned k = off; k < off + nb; k++) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
        if (nb == 4) known[d][idx] = 1'b1;
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit   mon_pend = 1'b0;
  int   mon_waits = 0;
  exp_t mon_e;

  always @(negedge hclk) begin
    if (!hresetn) begin
      if (mon_pend && exp_q.size() > 0) mon_e = exp_q.pop_front();
      mon_pend  = 1'b0;
      mon_waits = 0;
    end else begin
      if (mon_pend) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL queue_empty: data phase with no expected entry at %0t", $time);
          mon_pend = 1'b0;
        end else if (!hready) begin
          check("wait_hresp", 32'(hresp_m), 32'(exp_q[0].resp));
          check("wait_hrdata", hrdata_m, 32'd0);
          mon_waits++;
        end else begin
          mon_e = exp_q.pop_front();
          check("hresp", 32'(hresp_m), 32'(mon_e.resp));
          check("wait_count", 32'(mon_waits), 32'(mon_e.waits));
          if (mon_e.chk_rd) check("hrdata", hrdata_m, mon_e.rdata);
          mon_pend  = 1'b0;
          mon_waits = 0;
        end
      end else begin
        check("idle_hreadyout", 32'(hready), 32'd1);
        check("idle_hresp", 32'(hresp_m), 32'd0);
        check("idle_hrdata", hrdata_m, 32'd0);
      end
      if (hready && hsel_bus && htrans[1]) mon_pend = 1'b1;
    end
  end

  // ---------------- driver ----------------
  task automatic xfer(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                      input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    int n;
    hsel_bus = sel; htrans = tr; haddr = addr; hwrite = wr; hsize = sz;
    hburst = 3'($urandom_range(0, 7));
    hprot  = 4'($urandom_range(0, 15));
    n = 0;
    @(negedge hclk);
    while (!hready && n < 64) begin
      n++;
      @(negedge hclk);
    end
    if (!hready) begin
      checks++; errors++;
      $display("FAIL hready_timeout: hready low for %0d cycles at %0t", n, $time);
    end
    @(posedge hclk);
    if (sel && tr[1]) exp_q.push_back(model_xfer(act, addr, wr, sz, wd));
    #1;
    hwdata = wd;
  endtask

  task automatic wr_w(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b1, T_NSEQ, a, 1'b1, 3'b010, d);
  endtask

  task automatic rd_w(input logic [31:0] a);
    xfer(1'b1, T_NSEQ, a, 1'b0, 3'b010, $urandom);
  endtask

  task automatic idle_cyc();
    xfer(1'b0, T_IDLE, '0, 1'b0, 3'b010, '0);
  endtask

  task automatic select(input int d);
    idle_cyc();
    act = d;
    idle_cyc();
  endtask

  task automatic rand_xfer();
    logic        sel, wr;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] addr;
    int unsigned r, off;
    sel = ($urandom_range(0, 9) != 0);
    tr  = 2'($urandom_range(0, 3));
    wr  = 1'($urandom_range(0, 1));
    r   = $urandom_range(0, 9);
    sz  = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
    off = $urandom_range(0, 3);
    if (sz <= 3'd2) off = off - (off % (32'd1 << sz));
    addr = 32'($urandom_range(0, 255)) * 4 + off;
    r = $urandom_range(0, 19);
    if (r == 0) addr = 32'h400 + $urandom_range(0, 32'hFFFF);
    else if (r == 1) addr = addr | 32'($urandom_range(1, 3));
    xfer(sel, tr, addr, wr, sz, $urandom);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] saved_word;
  bit          saved_known;

  initial begin
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 256; i++) begin
        mdl[d][i]   = '0;
        known[d][i] = 1'b0;
      end
    repeat (3) @(posedge hclk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_hreadyout", 32'(hreadyout_v[d]), 32'd1);
      check("rst_hresp", 32'(hresp_v[d]), 32'd0);
      check("rst_hrdata", hrdata_v[d], 32'd0);
    end
    hresetn = 1'b1;

    for (int d = 0; d < ND; d++) begin
      select(d);
      for (int i = 0; i < 256; i++) wr_w(32'(i * 4), $urandom);
    end

    // zero wait states: back-to-back write/read, lanes, errors, idle/busy/unselected gaps
    select(0);
    wr_w(32'h10, 32'hDEADBEEF);
    rd_w(32'h10);
    wr_w(32'h20, 32'h0000_0000);
    xfer(1'b1, T_NSEQ, 32'h22, 1'b1, 3'b000, 32'h00AA_0000);
    xfer(1'b1, T_NSEQ, 32'h20, 1'b1, 3'b001, 32'h0000_1234);
    rd_w(32'h20);
    wr_w(32'h3, 32'h1111_1111);
    xfer(1'b1, T_NSEQ, 32'h0, 1'b1, 3'b011, 32'h2222_2222);
    wr_w(32'h400, 32'h3333_3333);
    rd_w(32'h0);
    wr_w(32'h30, 32'hA5A5_0001);
    xfer(1'b1, T_BUSY, 32'h34, 1'b1, 3'b010, 32'hBAD0_0001);
    xfer(1'b1, T_SEQ, 32'h34, 1'b1, 3'b010, 32'hA5A5_0002);
    xfer(1'b1, T_IDLE, 32'h38, 1'b1, 3'b010, 32'hBAD0_0002);
    xfer(1'b0, T_SEQ, 32'h38, 1'b1, 3'b010, 32'hBAD0_0003);
    xfer(1'b1, T_SEQ, 32'h3C, 1'b1, 3'b010, 32'hA5A5_0003);
    rd_w(32'h30); rd_w(32'h34); rd_w(32'h38); rd_w(32'h3C);

    // three wait states: held NONSEQ accepted on the completing edge, errors stay 2 cycles
    select(1);
    rd_w(32'h40);
    rd_w(32'h44);
    wr_w(32'h48, 32'hCAFE_F00D);
    rd_w(32'h48);
    wr_w(32'h3, 32'h1);
    xfer(1'b1, T_NSEQ, 32'h0, 1'b0, 3'b011, 32'h0);
    rd_w(32'h400);
    rd_w(32'h0);

    // two wait states: reset during WAIT aborts the write
    select(2);
    saved_word  = mdl[2][2];
    saved_known = known[2][2];
    wr_w(32'h8, 32'h5555_5555);
    #3;
    hresetn  = 1'b0;
    hsel_bus = 1'b0;
    htrans   = T_IDLE;
    #1;
    check("abort_hreadyout", 32'(hreadyout_v[2]), 32'd1);
    check("abort_hresp", 32'(hresp_v[2]), 32'd0);
    mdl[2][2]   = saved_word;
    known[2][2] = saved_known;
    @(posedge hclk);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    rd_w(32'h8);
    rd_w(32'hC);

    for (int d = 0; d < ND; d++) begin
      select(d);
      repeat (150) rand_xfer();
      for (int i = 0; i < 4; i++) rd_w(32'($urandom_range(0, 255)) * 4);
    end

    idle_cyc();
    idle_cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
